// File: rtl/instruction_decode_if.sv
// rtl/instruction_decode_if.sv - fetch/writeback inputs and ID/EX outputs of the decode stage (out_illegal present with ID_ILLEGAL_FLAG_EN)
interface instruction_decode_if #(
    parameter int len = 32
);
    logic [len-1:0] in_pc_jump;
    logic [len-1:0] in_instruction;
    logic           in_stall;
    logic           in_flush;
    logic           in_reg_write;
    logic [4:0]     in_write_reg;
    logic [len-1:0] in_write_data;

    logic           out_pc_src;
    logic [len-1:0] out_pc_target;
    logic [len-1:0] out_pc_jump;
    logic [len-1:0] out_read_data_1;
    logic [len-1:0] out_read_data_2;
    logic [len-1:0] out_immediate;
    logic [4:0]     out_rs;
    logic [4:0]     out_rt;
    logic [4:0]     out_write_reg;
    logic [5:0]     out_alu_op;
    logic           out_alu_src;
    logic [4:0]     out_shamt;
    logic           out_mem_read;
    logic           out_mem_write;
    logic           out_mem_to_reg;
    logic           out_reg_write;
    logic           out_link;
`ifdef ID_ILLEGAL_FLAG_EN
    logic           out_illegal;

    modport master (
        output in_pc_jump, in_instruction, in_stall, in_flush,
               in_reg_write, in_write_reg, in_write_data,
        input  out_pc_src, out_pc_target, out_pc_jump, out_read_data_1,
               out_read_data_2, out_immediate, out_rs, out_rt, out_write_reg,
               out_alu_op, out_alu_src, out_shamt, out_mem_read, out_mem_write,
               out_mem_to_reg, out_reg_write, out_link, out_illegal
    );

    modport slave (
        input  in_pc_jump, in_instruction, in_stall, in_flush,
               in_reg_write, in_write_reg, in_write_data,
        output out_pc_src, out_pc_target, out_pc_jump, out_read_data_1,
               out_read_data_2, out_immediate, out_rs, out_rt, out_write_reg,
               out_alu_op, out_alu_src, out_shamt, out_mem_read, out_mem_write,
               out_mem_to_reg, out_reg_write, out_link, out_illegal
    );
`else
    modport master (
        output in_pc_jump, in_instruction, in_stall, in_flush,
               in_reg_write, in_write_reg, in_write_data,
        input  out_pc_src, out_pc_target, out_pc_jump, out_read_data_1,
               out_read_data_2, out_immediate, out_rs, out_rt, out_write_reg,
               out_alu_op, out_alu_src, out_shamt, out_mem_read, out_mem_write,
               out_mem_to_reg, out_reg_write, out_link
    );

    modport slave (
        input  in_pc_jump, in_instruction, in_stall, in_flush,
               in_reg_write, in_write_reg, in_write_data,
        output out_pc_src, out_pc_target, out_pc_jump, out_read_data_1,
               out_read_data_2, out_immediate, out_rs, out_rt, out_write_reg,
               out_alu_op, out_alu_src, out_shamt, out_mem_read, out_mem_write,
               out_mem_to_reg, out_reg_write, out_link
    );
`endif
endinterface

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - ID stage: register file, decode, branch resolution, ID/EX register (optional ID_ILLEGAL_FLAG_EN)
module instruction_decode #(
    parameter int len      = 32,
    parameter int num_regs = 32
) (
    input logic                clk,
    input logic                reset,
    instruction_decode_if.slave bus
);
    localparam logic [5:0] op_rtype = 6'h00;
    localparam logic [5:0] op_j     = 6'h02;
    localparam logic [5:0] op_jal   = 6'h03;
    localparam logic [5:0] op_beq   = 6'h04;
    localparam logic [5:0] op_bne   = 6'h05;
    localparam logic [5:0] op_addi  = 6'h08;
    localparam logic [5:0] op_slti  = 6'h0A;
    localparam logic [5:0] op_andi  = 6'h0C;
    localparam logic [5:0] op_ori   = 6'h0D;
    localparam logic [5:0] op_xori  = 6'h0E;
    localparam logic [5:0] op_lui   = 6'h0F;
    localparam logic [5:0] op_lw    = 6'h23;
    localparam logic [5:0] op_sw    = 6'h2B;
    localparam logic [5:0] fn_jr    = 6'h08;
    localparam logic [5:0] fn_jalr  = 6'h09;

    typedef struct packed {
        logic [len-1:0] pc_jump;
        logic [len-1:0] read_data_1;
        logic [len-1:0] read_data_2;
        logic [len-1:0] immediate;
        logic [4:0]     rs;
        logic [4:0]     rt;
        logic [4:0]     write_reg;
        logic [5:0]     alu_op;
        logic           alu_src;
        logic [4:0]     shamt;
        logic           mem_read;
        logic           mem_write;
        logic           mem_to_reg;
        logic           reg_write;
        logic           link;
    } idex_t;

    logic [len-1:0] regs [num_regs];
    idex_t          idex_q;
    idex_t          dec;
    logic           legal;
    logic           bubble;
    logic           redirect;
    logic [len-1:0] rs_val;
    logic [len-1:0] rt_val;

    logic [5:0]     opcode;
    logic [4:0]     rs_f;
    logic [4:0]     rt_f;
    logic [4:0]     rd_f;
    logic [4:0]     shamt_f;
    logic [5:0]     funct;
    logic [15:0]    imm16;
    logic [len-1:0] imm_sext;
    logic [len-1:0] imm_zext;
    logic [len-1:0] branch_target;
    logic [len-1:0] jump_target;

    assign opcode        = bus.in_instruction[31:26];
    assign rs_f          = bus.in_instruction[25:21];
    assign rt_f          = bus.in_instruction[20:16];
    assign rd_f          = bus.in_instruction[15:11];
    assign shamt_f       = bus.in_instruction[10:6];
    assign funct         = bus.in_instruction[5:0];
    assign imm16         = bus.in_instruction[15:0];
    assign imm_sext      = {{(len-16){imm16[15]}}, imm16};
    assign imm_zext      = {{(len-16){1'b0}}, imm16};
    assign branch_target = bus.in_pc_jump + imm_sext;
    assign jump_target   = {bus.in_pc_jump[len-1:26], bus.in_instruction[25:0]};
    assign bubble        = bus.in_stall | bus.in_flush;

    // Register reads with same-cycle writeback bypass; r0 is hardwired to zero
    always_comb begin
        rs_val = regs[rs_f];
        rt_val = regs[rt_f];
        if (bus.in_reg_write && bus.in_write_reg == rs_f) rs_val = bus.in_write_data;
        if (bus.in_reg_write && bus.in_write_reg == rt_f) rt_val = bus.in_write_data;
        if (rs_f == 5'd0) rs_val = '0;
        if (rt_f == 5'd0) rt_val = '0;
    end

    // Register file write port; writes are never blocked by stall or flush
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < num_regs; i++) regs[i] <= '0;
        end else if (bus.in_reg_write && bus.in_write_reg != 5'd0) begin
            regs[bus.in_write_reg] <= bus.in_write_data;
        end
    end

    // Instruction decode into the next ID/EX contents; anything unrecognised stays a bubble
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            op_rtype: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, fn_jr, fn_jalr,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        legal         = 1'b1;
                        dec.alu_op    = funct;
                        dec.write_reg = rd_f;
                        dec.shamt     = shamt_f;
                        dec.reg_write = (funct != fn_jr);
                        dec.link      = (funct == fn_jalr);
                    end
                    default: legal = 1'b0;
                endcase
            end
            op_j: legal = 1'b1;
            op_jal: begin
                legal         = 1'b1;
                dec.reg_write = 1'b1;
                dec.link      = 1'b1;
                dec.write_reg = 5'd31;
                dec.immediate = imm_sext;
            end
            op_beq, op_bne: begin
                legal         = 1'b1;
                dec.immediate = imm_sext;
            end
            op_addi, op_slti, op_andi, op_ori, op_xori, op_lui, op_lw: begin
                legal         = 1'b1;
                dec.alu_src   = 1'b1;
                dec.write_reg = rt_f;
                dec.reg_write = 1'b1;
                dec.immediate = imm_sext;
                case (opcode)
                    op_slti: dec.alu_op = 6'h2A;
                    op_andi: begin dec.alu_op = 6'h24; dec.immediate = imm_zext; end
                    op_ori:  begin dec.alu_op = 6'h25; dec.immediate = imm_zext; end
                    op_xori: begin dec.alu_op = 6'h26; dec.immediate = imm_zext; end
                    op_lui:  begin dec.alu_op = 6'h20; dec.immediate = {imm16, {(len-16){1'b0}}}; end
                    default: dec.alu_op = 6'h20;
                endcase
                if (opcode == op_lw) begin
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                end
            end
            op_sw: begin
                legal         = 1'b1;
                dec.alu_op    = 6'h20;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.immediate = imm_sext;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            dec.pc_jump     = bus.in_pc_jump;
            dec.read_data_1 = rs_val;
            dec.read_data_2 = rt_val;
            dec.rs          = rs_f;
            dec.rt          = rt_f;
        end
    end

    // Branch and jump resolution feeding fetch in the same cycle
    always_comb begin
        redirect          = 1'b0;
        bus.out_pc_target = branch_target;
        case (opcode)
            op_beq: redirect = (rs_val == rt_val);
            op_bne: redirect = (rs_val != rt_val);
            op_j, op_jal: begin
                redirect          = 1'b1;
                bus.out_pc_target = jump_target;
            end
            op_rtype: begin
                if (funct == fn_jr || funct == fn_jalr) begin
                    redirect          = 1'b1;
                    bus.out_pc_target = rs_val;
                end
            end
            default: redirect = 1'b0;
        endcase
        bus.out_pc_src = redirect & ~bubble;
    end

    // ID/EX pipeline register; stall, flush and illegal encodings load a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else if (bubble || !legal) begin
            idex_q <= '0;
        end else begin
            idex_q <= dec;
        end
    end

`ifdef ID_ILLEGAL_FLAG_EN
    // One-cycle flag behind an unknown opcode/funct, dropped when a stall/flush bubble wins
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_illegal <= 1'b0;
        end else begin
            bus.out_illegal <= !bubble && !legal;
        end
    end
`endif

    assign bus.out_pc_jump     = idex_q.pc_jump;
    assign bus.out_read_data_1 = idex_q.read_data_1;
    assign bus.out_read_data_2 = idex_q.read_data_2;
    assign bus.out_immediate   = idex_q.immediate;
    assign bus.out_rs          = idex_q.rs;
    assign bus.out_rt          = idex_q.rt;
    assign bus.out_write_reg   = idex_q.write_reg;
    assign bus.out_alu_op      = idex_q.alu_op;
    assign bus.out_alu_src     = idex_q.alu_src;
    assign bus.out_shamt       = idex_q.shamt;
    assign bus.out_mem_read    = idex_q.mem_read;
    assign bus.out_mem_write   = idex_q.mem_write;
    assign bus.out_mem_to_reg  = idex_q.mem_to_reg;
    assign bus.out_reg_write   = idex_q.reg_write;
    assign bus.out_link        = idex_q.link;
endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - scoreboard bench for instruction_decode (honours ID_ILLEGAL_FLAG_EN)
module tb_instruction_decode;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [5:0]  alu;
        logic        asrc;
        logic [4:0]  sh;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic        lk;
        logic        ill;
    } exp_t;

    typedef struct {
        int   cyc;
        int   vec;
        exp_t e;
    } entry_t;

    logic   clk;
    logic   reset;
    int     cyc;
    int     vec;
    int     errors;
    int     checks;
    entry_t sb_q[$];

    instruction_decode_if #(.len(32)) bus ();

    instruction_decode #(.len(32), .num_regs(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] a);
        return {op, a};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, rd1, rd2, imm, input logic [4:0] rs, rt, wr,
                                input logic [5:0] alu, input logic asrc, input logic [4:0] sh,
                                input logic mr, mw, m2r, rw, lk);
        exp_t e;
        e = '{pc:pc, rd1:rd1, rd2:rd2, imm:imm, rs:rs, rt:rt, wr:wr, alu:alu, asrc:asrc,
              sh:sh, mr:mr, mw:mw, m2r:m2r, rw:rw, lk:lk, ill:1'b0};
        return e;
    endfunction

    function automatic exp_t bubble_exp(input logic ill);
        exp_t e;
        e = '0;
        e.ill = ill;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.pc   = bus.out_pc_jump;
        a.rd1  = bus.out_read_data_1;
        a.rd2  = bus.out_read_data_2;
        a.imm  = bus.out_immediate;
        a.rs   = bus.out_rs;
        a.rt   = bus.out_rt;
        a.wr   = bus.out_write_reg;
        a.alu  = bus.out_alu_op;
        a.asrc = bus.out_alu_src;
        a.sh   = bus.out_shamt;
        a.mr   = bus.out_mem_read;
        a.mw   = bus.out_mem_write;
        a.m2r  = bus.out_mem_to_reg;
        a.rw   = bus.out_reg_write;
        a.lk   = bus.out_link;
`ifdef ID_ILLEGAL_FLAG_EN
        a.ill  = bus.out_illegal;
`else
        a.ill  = 1'b0;
`endif
        return a;
    endfunction

    // Drive one vector, check the combinational redirect, queue the registered expectation
    task automatic issue(input logic [31:0] instr, pc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic st, fl, input logic esrc,
                         input logic [31:0] etgt, input exp_t e);
        entry_t en;
        @(posedge clk);
        #1;
        bus.in_instruction = instr;
        bus.in_pc_jump     = pc;
        bus.in_reg_write   = we;
        bus.in_write_reg   = wa;
        bus.in_write_data  = wd;
        bus.in_stall       = st;
        bus.in_flush       = fl;
        #1;
        vec++;
        checks++;
        if (bus.out_pc_src !== esrc) begin
            errors++;
            $display("FAIL pc_src vec%0d: got %b expected %b", vec, bus.out_pc_src, esrc);
        end
        if (esrc) begin
            checks++;
            if (bus.out_pc_target !== etgt) begin
                errors++;
                $display("FAIL pc_target vec%0d: got %h expected %h", vec, bus.out_pc_target, etgt);
            end
        end
`ifndef ID_ILLEGAL_FLAG_EN
        e.ill = 1'b0;
`endif
        en.cyc = cyc;
        en.vec = vec;
        en.e   = e;
        sb_q.push_back(en);
    endtask

    // Monitor: each queued expectation is compared the cycle after it was issued
    always @(negedge clk) begin
        if (sb_q.size() > 0 && cyc == sb_q[0].cyc + 1) begin
            entry_t en;
            exp_t   a;
            en = sb_q.pop_front();
            a  = actual();
            checks++;
            if (a !== en.e) begin
                errors++;
                $display("FAIL idex vec%0d: got %h expected %h", en.vec, a, en.e);
            end
        end
    end

    localparam logic [31:0] nowr = 32'h0;

    initial begin
        errors = 0;
        checks = 0;
        vec    = 0;
        reset  = 1'b1;
        bus.in_instruction = jtype(6'h03, 26'h100);
        bus.in_pc_jump     = 32'h20;
        bus.in_reg_write   = 1'b0;
        bus.in_write_reg   = 5'd0;
        bus.in_write_data  = '0;
        bus.in_stall       = 1'b0;
        bus.in_flush       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (actual() !== bubble_exp(1'b0)) begin
            errors++;
            $display("FAIL reset_idex: got %h expected 0", actual());
        end
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 1; i < 32; i++) begin
            issue(rtype(5'(i), 5'(i), 5'd3, 5'd0, 6'h20), 32'h100 + i, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
                  1'b0, 32'h0, mk(32'h100 + i, 0, 0, 0, 5'(i), 5'(i), 5'd3, 6'h20, 0, 0, 0, 0, 0, 1, 0));
        end

        issue(rtype(5'd5, 5'd0, 5'd3, 5'd0, 6'h20), 32'h4, 1'b1, 5'd5, 32'hAA, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h4, 32'hAA, 0, 0, 5'd5, 5'd0, 5'd3, 6'h20, 0, 0, 0, 0, 0, 1, 0));
        issue(rtype(5'd0, 5'd5, 5'd3, 5'd0, 6'h20), 32'h5, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h5, 0, 32'hAA, 0, 5'd0, 5'd5, 5'd3, 6'h20, 0, 0, 0, 0, 0, 1, 0));
        issue(rtype(5'd5, 5'd0, 5'd3, 5'd0, 6'h20), 32'h6, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h6, 32'hAA, 0, 0, 5'd5, 5'd0, 5'd3, 6'h20, 0, 0, 0, 0, 0, 1, 0));
        issue(rtype(5'd5, 5'd0, 5'd3, 5'd0, 6'h20), 32'h7, 1'b1, 5'd1, 32'h7, 1'b1, 1'b0,
              1'b0, 32'h0, bubble_exp(1'b0));
        issue(rtype(5'd5, 5'd0, 5'd3, 5'd0, 6'h20), 32'h8, 1'b1, 5'd2, 32'h7, 1'b1, 1'b0,
              1'b0, 32'h0, bubble_exp(1'b0));

        issue(itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'd10, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b1, 32'd8, mk(32'd10, 7, 7, 32'hFFFF_FFFE, 5'd1, 5'd2, 5'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0));
        issue(itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'd10, 1'b1, 5'd2, 32'h8, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'd10, 7, 8, 32'hFFFF_FFFE, 5'd1, 5'd2, 5'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0));
        issue(itype(6'h05, 5'd1, 5'd2, 16'h0003), 32'd10, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b1, 32'd13, mk(32'd10, 7, 8, 32'h3, 5'd1, 5'd2, 5'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0));

        issue(jtype(6'h03, 26'h100), 32'h20, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b1, 32'h100, mk(32'h20, 0, 0, 32'h100, 5'd0, 5'd0, 5'd31, 6'h00, 0, 0, 0, 0, 0, 1, 1));
        issue(jtype(6'h02, 26'h3FF_FFFF), 32'hF000_0004, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b1, 32'hF3FF_FFFF, mk(32'hF000_0004, 0, 0, 0, 5'd31, 5'd31, 5'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0));

        issue(itype(6'h0C, 5'd1, 5'd4, 16'h8001), 32'h50, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h50, 7, 0, 32'h0000_8001, 5'd1, 5'd4, 5'd4, 6'h24, 1, 0, 0, 0, 0, 1, 0));
        issue(itype(6'h08, 5'd1, 5'd4, 16'h8001), 32'h51, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h51, 7, 0, 32'hFFFF_8001, 5'd1, 5'd4, 5'd4, 6'h20, 1, 0, 0, 0, 0, 1, 0));
        issue(itype(6'h0D, 5'd1, 5'd8, 16'hFFFF), 32'h52, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h52, 7, 0, 32'h0000_FFFF, 5'd1, 5'd8, 5'd8, 6'h25, 1, 0, 0, 0, 0, 1, 0));
        issue(itype(6'h0E, 5'd1, 5'd8, 16'h8000), 32'h53, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h53, 7, 0, 32'h0000_8000, 5'd1, 5'd8, 5'd8, 6'h26, 1, 0, 0, 0, 0, 1, 0));
        issue(itype(6'h0A, 5'd1, 5'd8, 16'h8000), 32'h54, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h54, 7, 0, 32'hFFFF_8000, 5'd1, 5'd8, 5'd8, 6'h2A, 1, 0, 0, 0, 0, 1, 0));
        issue(itype(6'h0F, 5'd0, 5'd6, 16'h1234), 32'h55, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h55, 0, 0, 32'h1234_0000, 5'd0, 5'd6, 5'd6, 6'h20, 1, 0, 0, 0, 0, 1, 0));
        issue(itype(6'h23, 5'd1, 5'd7, 16'h0004), 32'h56, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h56, 7, 0, 32'h4, 5'd1, 5'd7, 5'd7, 6'h20, 1, 0, 1, 0, 1, 1, 0));
        issue(itype(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h57, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h57, 7, 8, 32'h8, 5'd1, 5'd2, 5'd0, 6'h20, 1, 0, 0, 1, 0, 0, 0));

        issue(rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 32'h40, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b1, 32'h7, mk(32'h40, 7, 0, 0, 5'd1, 5'd0, 5'd0, 6'h08, 0, 0, 0, 0, 0, 0, 0));
        issue(rtype(5'd2, 5'd0, 5'd31, 5'd0, 6'h09), 32'h44, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b1, 32'h8, mk(32'h44, 8, 0, 0, 5'd2, 5'd0, 5'd31, 6'h09, 0, 0, 0, 0, 0, 1, 1));
        issue(rtype(5'd0, 5'd1, 5'd9, 5'd5, 6'h00), 32'h48, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h48, 0, 7, 0, 5'd0, 5'd1, 5'd9, 6'h00, 0, 5'd5, 0, 0, 0, 1, 0));
        issue(32'h0, 32'h60, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h60, 0, 0, 0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 0, 0, 0, 0, 1, 0));

        issue(itype(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'd10, 1'b0, 5'd0, nowr, 1'b1, 1'b0,
              1'b0, 32'h0, bubble_exp(1'b0));
        issue(itype(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'd10, 1'b0, 5'd0, nowr, 1'b0, 1'b1,
              1'b0, 32'h0, bubble_exp(1'b0));
        issue({6'h3F, 26'h0}, 32'h70, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, bubble_exp(1'b1));
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'h71, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, bubble_exp(1'b1));
        issue(rtype(5'd5, 5'd0, 5'd3, 5'd0, 6'h20), 32'h72, 1'b0, 5'd0, nowr, 1'b0, 1'b0,
              1'b0, 32'h0, mk(32'h72, 32'hAA, 0, 0, 5'd5, 5'd0, 5'd3, 6'h20, 0, 0, 0, 0, 0, 1, 0));
        issue({6'h3F, 26'h0}, 32'h73, 1'b0, 5'd0, nowr, 1'b1, 1'b0,
              1'b0, 32'h0, bubble_exp(1'b0));

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
